// File: rtl/encoder8_3_db.sv
// Debounced, registered 8-to-3 priority encoder for board switches and keys.
// Raw inputs are synchronised, held stable for CNT_MAX clocks, then the index
// of the highest set bit is emitted as a one-cycle event. A new event is only
// possible after the inputs have been debounced back to all-zero.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | no keys seen, counter parked at 0
// PRESS_DB   | nonzero pattern seen, counting stable cycles of snap
// HELD       | event issued, waiting for all keys released
// RELEASE_DB | all-zero seen, counting stable cycles before re-arming
module encoder8_3_db #(
    parameter int CNT_MAX = 1_000_000,
    parameter int CNT_W   = 20
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [7:0] key_in,
    output logic [2:0] code,
    output logic       code_vld,
    output logic       multi,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

    logic [7:0]       sync1;
    logic [7:0]       s;
    logic [7:0]       snap;
    logic [CNT_W-1:0] cnt;
    state_t           state;

    // Bit 7 has the highest priority: the last set bit scanned wins.
    function automatic logic [2:0] prio(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // Clearing the lowest set bit leaves something only if two or more were set.
    function automatic logic many(input logic [7:0] v);
        return (v & (v - 8'd1)) != 8'd0;
    endfunction

    // Two-flop synchroniser; s is the only view of the pins the FSM uses.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1 <= 8'd0;
            s     <= 8'd0;
        end else begin
            sync1 <= key_in;
            s     <= sync1;
        end
    end

    // Debounce FSM with registered event outputs.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= IDLE;
            snap     <= 8'd0;
            cnt      <= '0;
            code     <= 3'd0;
            code_vld <= 1'b0;
            multi    <= 1'b0;
        end else begin
            code_vld <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (s != 8'd0) begin
                        snap  <= s;
                        state <= PRESS_DB;
                    end
                end
                PRESS_DB: begin
                    if (s == 8'd0) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else if (s != snap) begin
                        snap <= s;
                        cnt  <= '0;
                    end else if (cnt == CNT_LAST) begin
                        code     <= prio(snap);
                        multi    <= many(snap);
                        code_vld <= 1'b1;
                        cnt      <= '0;
                        state    <= HELD;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                HELD: begin
                    cnt <= '0;
                    if (s == 8'd0) state <= RELEASE_DB;
                end
                RELEASE_DB: begin
                    if (s != 8'd0) begin
                        cnt   <= '0;
                        state <= HELD;
                    end else if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // busy is a decode of the state register only, so it is glitch-free.
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_encoder8_3_db.sv
// Directed bench for encoder8_3_db with CNT_MAX=4. Step labels c<n> count
// rising edges since the step's first input change (driven #1 after an edge).
module tb_encoder8_3_db;

    logic       sys_clk;
    logic       sys_rst_n;
    logic [7:0] key_in;
    logic [2:0] code;
    logic       code_vld;
    logic       multi;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int p0;

    encoder8_3_db #(.CNT_MAX(4), .CNT_W(3)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .key_in    (key_in),
        .code      (code),
        .code_vld  (code_vld),
        .multi     (multi),
        .busy      (busy)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Pulse counter sampled mid-cycle.
    always @(negedge sys_clk) if (code_vld === 1'b1) pulses <= pulses + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 40) begin
            tick(1);
            n++;
        end
        chk(tag, int'(busy), 0);
    endtask

    initial begin
        sys_rst_n = 1'b0;
        key_in    = 8'h00;
        tick(2);
        chk("rst_code", int'(code), 0);
        chk("rst_vld", int'(code_vld), 0);
        chk("rst_multi", int'(multi), 0);
        chk("rst_busy", int'(busy), 0);
        sys_rst_n = 1'b1;
        tick(8);

        // 1: two keys, clean press
        p0 = pulses;
        key_in = 8'h24;
        tick(2);  chk("t1_busy_c2", int'(busy), 0);
        tick(1);  chk("t1_busy_c3", int'(busy), 1);
        tick(3);  chk("t1_vld_c6", int'(code_vld), 0);
        tick(1);  chk("t1_vld_c7", int'(code_vld), 1);
        chk("t1_code", int'(code), 5);
        chk("t1_multi", int'(multi), 1);
        tick(1);  chk("t1_vld_c8", int'(code_vld), 0);
        tick(22); chk("t1_pulses", pulses - p0, 1);
        key_in = 8'h00;
        tick(6);  chk("t1_rel_busy_c6", int'(busy), 1);
        tick(1);  chk("t1_rel_busy_c7", int'(busy), 0);

        // 2: bouncing bit 3, final edge at c8
        tick(3);
        p0 = pulses;
        key_in = 8'h08; tick(2);
        key_in = 8'h00; tick(2);
        key_in = 8'h08; tick(2);
        key_in = 8'h00; tick(2);
        key_in = 8'h08;
        tick(6);  chk("t2_no_early", pulses - p0, 0);
        chk("t2_vld_c14", int'(code_vld), 0);
        tick(1);  chk("t2_vld_c15", int'(code_vld), 1);
        chk("t2_code", int'(code), 3);
        chk("t2_multi", int'(multi), 0);
        tick(5);
        key_in = 8'h00;
        wait_idle("t2_idle");

        // 3: three-cycle glitch
        tick(3);
        p0 = pulses;
        key_in = 8'h40;
        tick(3);
        key_in = 8'h00;
        tick(2);  chk("t3_busy_c5", int'(busy), 1);
        tick(1);  chk("t3_busy_c6", int'(busy), 0);
        tick(6);  chk("t3_pulses", pulses - p0, 0);
        chk("t3_code_hold", int'(code), 3);
        chk("t3_multi_hold", int'(multi), 0);

        // 4: press, bouncy release, second press
        p0 = pulses;
        key_in = 8'h01;
        tick(7);  chk("t4_vld1", int'(code_vld), 1);
        chk("t4_code1", int'(code), 0);
        tick(3);
        key_in = 8'h00; tick(2);
        key_in = 8'h01; tick(2);
        key_in = 8'h00; tick(2);
        key_in = 8'h01; tick(2);
        key_in = 8'h00;
        tick(6);  chk("t4_rel_busy_c24", int'(busy), 1);
        tick(1);  chk("t4_rel_busy_c25", int'(busy), 0);
        tick(3);
        chk("t4_one_so_far", pulses - p0, 1);
        key_in = 8'h80;
        tick(6);  chk("t4_vld2_c34", int'(code_vld), 0);
        tick(1);  chk("t4_vld2_c35", int'(code_vld), 1);
        chk("t4_code2", int'(code), 7);
        chk("t4_multi2", int'(multi), 0);
        tick(2);  chk("t4_pulses", pulses - p0, 2);
        key_in = 8'h00;
        wait_idle("t4_idle");

        // 5: pattern changes while held
        tick(3);
        p0 = pulses;
        key_in = 8'h01;
        tick(7);  chk("t5_vld", int'(code_vld), 1);
        tick(3);
        key_in = 8'h03;
        tick(15);
        chk("t5_pulses", pulses - p0, 1);
        chk("t5_code", int'(code), 0);
        chk("t5_multi", int'(multi), 0);
        chk("t5_busy", int'(busy), 1);
        key_in = 8'h00;
        wait_idle("t5_idle");

        // 6: reset during PRESS_DB with the key held throughout
        tick(3);
        p0 = pulses;
        key_in = 8'h10;
        tick(4);  chk("t6_busy_pre", int'(busy), 1);
        sys_rst_n = 1'b0;
        #1;
        chk("t6_rst_code", int'(code), 0);
        chk("t6_rst_multi", int'(multi), 0);
        chk("t6_rst_vld", int'(code_vld), 0);
        chk("t6_rst_busy", int'(busy), 0);
        tick(2);
        sys_rst_n = 1'b1;
        tick(6);  chk("t6_vld_c12", int'(code_vld), 0);
        tick(1);  chk("t6_vld_c13", int'(code_vld), 1);
        chk("t6_code", int'(code), 4);
        chk("t6_multi", int'(multi), 0);
        tick(2);  chk("t6_pulses", pulses - p0, 1);
        key_in = 8'h00;
        wait_idle("t6_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
